// File: rtl/fma_rr_arbiter.sv
// Round-robin front end sharing one pipelined FP32 FMA among NREQ requesters.
// Latency: grant is combinational; resp_valid follows a transfer by FMA_LAT+1 cycles.
// Backpressure: none from the FMA; only hold and the rotating scan gate req_ready.
module fma_rr_arbiter #(
    parameter int NREQ    = 4,
    parameter int FMA_LAT = 1,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          hold,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ*32-1:0]            req_a,
    input  logic [NREQ*32-1:0]            req_b,
    input  logic [NREQ*32-1:0]            req_c,
    output logic [31:0]                   fma_a,
    output logic [31:0]                   fma_b,
    output logic [31:0]                   fma_c,
    input  logic [31:0]                   fma_result,
    output logic [NREQ-1:0]               resp_valid,
    output logic [31:0]                   resp_data,
    output logic [IDW-1:0]                resp_id,
    output logic [$clog2(FMA_LAT+2)-1:0]  in_flight,
    output logic                          busy
);
    localparam int DEPTH = FMA_LAT + 1;
    localparam int IFW   = $clog2(FMA_LAT + 2);

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
    } tag_t;

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] gnt_id;
    logic [IDW-1:0] scan_idx;
    logic           gnt_hit;
    logic           xfer;
    logic [31:0]    a_arr [NREQ];
    logic [31:0]    b_arr [NREQ];
    logic [31:0]    c_arr [NREQ];
    tag_t           tag_q [DEPTH];
    tag_t           tag_out;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = req_a[32*i +: 32];
            b_arr[i] = req_b[32*i +: 32];
            c_arr[i] = req_c[32*i +: 32];
        end
    end

    // First valid requester at or after ptr, wrapping around.
    always_comb begin
        gnt_hit  = 1'b0;
        gnt_id   = '0;
        scan_idx = '0;
        for (int off = 0; off < NREQ; off++) begin
            scan_idx = IDW'((int'(ptr) + off) % NREQ);
            if (!gnt_hit && req_valid[scan_idx]) begin
                gnt_hit = 1'b1;
                gnt_id  = scan_idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && !hold && gnt_hit)
            req_ready = NREQ'(1) << gnt_id;
    end

    assign xfer = |(req_valid & req_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            fma_a <= '0;
            fma_b <= '0;
            fma_c <= '0;
        end else if (xfer) begin
            ptr   <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
            fma_a <= a_arr[gnt_id];
            fma_b <= b_arr[gnt_id];
            fma_c <= c_arr[gnt_id];
        end
    end

    // One tag stage for the operand register plus FMA_LAT for the FMA itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                tag_q[i] <= '0;
        end else begin
            tag_q[0] <= tag_t'{vld: xfer, id: gnt_id};
            for (int i = 1; i < DEPTH; i++)
                tag_q[i] <= tag_q[i-1];
        end
    end

    assign tag_out = tag_q[DEPTH-1];

    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < NREQ; i++)
            resp_valid[i] = tag_out.vld && (tag_out.id == IDW'(i));
    end

    assign resp_id   = tag_out.vld ? tag_out.id : '0;
    assign resp_data = tag_out.vld ? fma_result : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight <= '0;
        end else begin
            case ({xfer, tag_out.vld})
                2'b10:   in_flight <= in_flight + IFW'(1);
                2'b01:   in_flight <= in_flight - IFW'(1);
                default: in_flight <= in_flight;
            endcase
        end
    end

    assign busy = (in_flight != '0);

endmodule

// File: tb/tb_fma_rr_arbiter.sv
// Bench for fma_rr_arbiter: FMA_LAT=1 and FMA_LAT=3 instances share stimulus,
// each fed by a behavioural FMA; a scoreboard tracks every issued operation.
module tb_fma_rr_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst_n;
    logic              hold;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*32-1:0] req_a, req_b, req_c;

    logic [NREQ-1:0] rdy_w  [2];
    logic [NREQ-1:0] rv_w   [2];
    logic [31:0]     rd_w   [2];
    logic [IDW-1:0]  rid_w  [2];
    logic [2:0]      inf_w  [2];
    logic            busy_w [2];
    logic [31:0]     fa_w   [2];

    typedef struct {
        int          inst;
        int          id;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   mptr = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic real f2r(input logic [31:0] f);
        real m;
        int  e;
        if (f[30:0] == 31'd0) return 0.0;
        m = 1.0 + real'(f[22:0]) / 8388608.0;
        e = int'(f[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return f[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic s;
        int   e;
        real  m;
        if (r == 0.0) return 32'd0;
        s = (r < 0.0);
        m = s ? -r : r;
        e = 127;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        return {s, 8'(e), 23'($rtoi((m - 1.0) * 8388608.0))};
    endfunction

    function automatic logic [31:0] fma_ref(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return r2f(f2r(a) * f2r(b) + f2r(c));
    endfunction

    function automatic logic [NREQ-1:0] model_grant(input logic [NREQ-1:0] v, input int p, input logic h);
        if (h) return '0;
        for (int n = 0; n < NREQ; n++)
            if (v[(p + n) % NREQ]) return NREQ'(1) << ((p + n) % NREQ);
        return '0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_dut
        localparam int L   = (k == 0) ? 1 : 3;
        localparam int IFW = $clog2(L + 2);
        logic [NREQ-1:0] rdy, rv;
        logic [31:0]     fa, fb, fc, fres, rd;
        logic [IDW-1:0]  rid;
        logic [IFW-1:0]  inf;
        logic            bsy;
        logic [31:0]     pipe [L];

        fma_rr_arbiter #(.NREQ(NREQ), .FMA_LAT(L), .IDW(IDW)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .hold       (hold),
            .req_valid  (req_valid),
            .req_ready  (rdy),
            .req_a      (req_a),
            .req_b      (req_b),
            .req_c      (req_c),
            .fma_a      (fa),
            .fma_b      (fb),
            .fma_c      (fc),
            .fma_result (fres),
            .resp_valid (rv),
            .resp_data  (rd),
            .resp_id    (rid),
            .in_flight  (inf),
            .busy       (bsy)
        );

        // Behavioural FMA: L register stages after the operand registers.
        always @(posedge clk) begin
            pipe[0] <= fma_ref(fa, fb, fc);
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
        assign fres = pipe[L-1];

        assign rdy_w[k]  = rdy;
        assign rv_w[k]   = rv;
        assign rd_w[k]   = rd;
        assign rid_w[k]  = rid;
        assign inf_w[k]  = 3'(inf);
        assign busy_w[k] = bsy;
        assign fa_w[k]   = fa;
    end

    always @(negedge clk) begin
        logic [NREQ-1:0] eg;
        int gid, cnt, qi;
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("rst_rdy%0d", k), 32'(rdy_w[k]), 32'd0);
                check($sformatf("rst_rv%0d", k), 32'(rv_w[k]), 32'd0);
                check($sformatf("rst_inf%0d", k), 32'(inf_w[k]), 32'd0);
                check($sformatf("rst_fa%0d", k), fa_w[k], 32'd0);
            end
            sbq.delete();
            mptr = 0;
        end else begin
            eg = model_grant(req_valid, mptr, hold);
            for (int k = 0; k < 2; k++) begin
                check($sformatf("rdy%0d", k), 32'(rdy_w[k]), 32'(eg));
                cnt = 0;
                qi  = -1;
                for (int j = 0; j < sbq.size(); j++)
                    if (sbq[j].inst == k) begin
                        cnt++;
                        if (qi < 0) qi = j;
                    end
                check($sformatf("inflight%0d", k), 32'(inf_w[k]), 32'(cnt));
                check($sformatf("busy%0d", k), 32'(busy_w[k]), 32'(cnt != 0));
                if (rv_w[k] != '0) begin
                    if (qi < 0) begin
                        check($sformatf("spurious_resp%0d", k), 32'(rv_w[k]), 32'd0);
                    end else begin
                        check($sformatf("resp_vld%0d", k), 32'(rv_w[k]), 32'(1) << sbq[qi].id);
                        check($sformatf("resp_id%0d", k), 32'(rid_w[k]), 32'(sbq[qi].id));
                        check($sformatf("resp_data%0d", k), rd_w[k], sbq[qi].data);
                        check($sformatf("resp_lat%0d", k), 32'(cyc), 32'(sbq[qi].due));
                        sbq.delete(qi);
                    end
                end else if (qi >= 0 && sbq[qi].due <= cyc) begin
                    check($sformatf("missing_resp%0d", k), 32'(rv_w[k]), 32'(1) << sbq[qi].id);
                    sbq.delete(qi);
                end
            end
            if (eg != '0) begin
                gid = 0;
                for (int j = 0; j < NREQ; j++) if (eg[j]) gid = j;
                sbq.push_back('{0, gid, fma_ref(req_a[32*gid +: 32], req_b[32*gid +: 32], req_c[32*gid +: 32]), cyc + 2});
                sbq.push_back('{1, gid, fma_ref(req_a[32*gid +: 32], req_b[32*gid +: 32], req_c[32*gid +: 32]), cyc + 4});
                mptr = (gid + 1) % NREQ;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a[32*i +: 32] = r2f(real'($urandom_range(0, 20)) - 10.0);
            req_b[32*i +: 32] = r2f(real'($urandom_range(0, 20)) - 10.0);
            req_c[32*i +: 32] = r2f(real'($urandom_range(0, 40)) - 20.0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; hold = 1'b0; req_valid = '0;
        req_a = '0; req_b = '0; req_c = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 2*3+1 from requester 2.
        req_valid = 4'b0100;
        req_a[64 +: 32] = 32'h40000000;
        req_b[64 +: 32] = 32'h40400000;
        req_c[64 +: 32] = 32'h3F800000;
        @(negedge clk); check("single_rdy", 32'(rdy_w[0]), 32'h4);
        tick(); req_valid = '0;
        @(negedge clk); check("single_inf_a", 32'(inf_w[0]), 32'd1);
        tick();
        @(negedge clk);
        check("single_rv", 32'(rv_w[0]), 32'h4);
        check("single_id", 32'(rid_w[0]), 32'd2);
        check("single_data", rd_w[0], 32'h40E00000);
        check("single_inf_b", 32'(inf_w[0]), 32'd1);
        tick();
        @(negedge clk); check("single_inf_c", 32'(inf_w[0]), 32'd0);

        // Serve requester 3 alone so the pointer wraps to 0, then saturate.
        tick(); req_valid = 4'b1000; set_ops();
        @(negedge clk); check("wrap_rdy", 32'(rdy_w[0]), 32'h8);
        for (int i = 0; i < 10; i++) begin
            tick(); req_valid = 4'b1111; set_ops();
            @(negedge clk);
            check("rr_order", 32'(rdy_w[0]), 32'(1) << (i % 4));
            if (i >= 2) check("inf_sat_lat1", 32'(inf_w[0]), 32'd2);
            if (i >= 4) check("inf_peak_lat3", 32'(inf_w[1]), 32'd4);
        end

        // Hold with operations in flight; pointer is 2 here.
        tick(); hold = 1'b1; req_valid = 4'b1010;
        @(negedge clk);
        check("hold_rdy", 32'(rdy_w[0]), 32'd0);
        check("hold_inf", 32'(inf_w[0]), 32'd2);
        repeat (4) tick();
        @(negedge clk);
        check("hold_drain0", 32'(busy_w[0]), 32'd0);
        check("hold_drain1", 32'(busy_w[1]), 32'd0);
        tick(); hold = 1'b0;
        @(negedge clk); check("resume_first", 32'(rdy_w[0]), 32'h8);
        tick();
        @(negedge clk); check("resume_next", 32'(rdy_w[0]), 32'h2);
        tick(); req_valid = '0;

        // Async reset with two operations outstanding.
        tick(); req_valid = 4'b1111; set_ops();
        tick(); set_ops();
        tick(); rst_n = 1'b0; req_valid = 4'b0110;
        #1;
        check("arst_rdy", 32'(rdy_w[0]), 32'd0);
        check("arst_rv", 32'(rv_w[0]), 32'd0);
        check("arst_inf", 32'(inf_w[0]), 32'd0);
        check("arst_busy", 32'(busy_w[1]), 32'd0);
        check("arst_fa", fa_w[0], 32'd0);
        tick(); tick(); rst_n = 1'b1;
        @(negedge clk); check("post_rst_rdy", 32'(rdy_w[0]), 32'h2);
        tick(); req_valid = '0;
        repeat (6) tick();

        // Random traffic with occasional hold.
        repeat (300) begin
            tick();
            req_valid = NREQ'($urandom);
            hold = ($urandom_range(0, 7) == 0);
            set_ops();
        end
        tick(); req_valid = '0; hold = 1'b0;
        repeat (8) tick();
        @(negedge clk); check("drain_empty", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fma_rr_arbiter.md
Name: fma_rr_arbiter

Overview:
- Shares one fixed-latency FP32 fused multiply-add unit (result = a*b+c, registered output) among NREQ requesters.
- Round-robin arbitration: at most one operation issued per cycle.
- Each issued operation is tagged with its requester id, and the id travels down a shift pipeline that matches the FMA latency.
- When the result emerges, it is returned to the originating requester.
- Sits between the vector/scalar clients and the single FMA_32 instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- FMA_LAT, 1, cycles from operands presented at the FMA inputs to the result appearing on fma_result (FMA_32 = 1).
- IDW, 2, width of requester id, equal to clog2(NREQ).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- hold  in  1  when 1, no new grants are issued; in-flight operations still complete.
- req_valid  in  NREQ  per-requester operation valid.
- req_ready  out  NREQ  one-hot grant; a transfer happens when req_valid[i] & req_ready[i].
- req_a  in  NREQ*32  packed operand a; requester i occupies bits [32i+31:32i].
- req_b  in  NREQ*32  packed operand b.
- req_c  in  NREQ*32  packed addend c.
- fma_a  out  32  registered operand a to the FMA.
- fma_b  out  32  registered operand b to the FMA.
- fma_c  out  32  registered operand c to the FMA.
- fma_result  in  32  FMA output.
- resp_valid  out  NREQ  one-hot, 1-cycle result strobe.
- resp_data  out  32  result, broadcast to all requesters; valid only with resp_valid.
- resp_id  out  IDW  id of the requester that owns resp_data.
- in_flight  out  clog2(FMA_LAT+2)  number of operations issued but not yet returned.
- busy  out  1  in_flight != 0.

Behaviour:
- Reset (async, rst_n=0):
  - fma_a/b/c = 0, resp_valid = 0, resp_data = 0, resp_id = 0.
  - in_flight = 0, rr pointer = 0, tag pipeline cleared.
  - req_ready = 0 while rst_n = 0.
  - Operations in flight at reset assertion are dropped; no response is ever produced for them.
- Grant (combinational):
  - If hold = 0, scan req_valid cyclically from index ptr; the first set bit i gets req_ready[i] = 1.
  - Otherwise req_ready = 0.
  - req_ready depends on req_valid and ptr only; there is no dependency on downstream state, because the FMA is fully pipelined and never stalls.
- Pointer update:
  - On a transfer with id g, ptr <= (g+1) mod NREQ.
  - Without a transfer, ptr holds its value.
  - Requesters that keep valid asserted are served in strict rotation; none waits more than NREQ-1 grants.
- Issue stage:
  - On a transfer, fma_a/b/c <= req_a/b/c slice g.
  - Without a transfer, fma_a/b/c hold their previous value (no toggling).
- Tag pipeline:
  - Depth FMA_LAT+1 entries of {valid, id}.
  - Stage 0 <= {transfer, g}; each later stage shifts forward every cycle.
  - Total request-to-response latency is FMA_LAT+1 cycles: a transfer in cycle T produces its response in cycle T+1+FMA_LAT.
- Response:
  - When the last tag stage is valid with id k: resp_valid[k] = 1, resp_id = k, resp_data = fma_result.
  - resp_data and resp_id are driven combinationally from fma_result and the tag.
  - Otherwise resp_valid = 0.
  - There is no response backpressure; requesters must accept the result in that cycle.
- in_flight:
  - Incremented by a transfer and decremented by a response.
  - A transfer and a response in the same cycle leave it unchanged.
  - Maximum value is FMA_LAT+1, which can never overflow.
- Boundary conditions:
  - Back-to-back issue every cycle is allowed from the same or different requesters.
  - A single active requester is granted every cycle.
  - If hold rises while operations are in flight, those operations complete and busy falls after they drain.
  - When hold falls, arbitration resumes from the current ptr.
  - If req_valid drops before being granted, no transfer occurs and ptr is unchanged.

Test Plan:
- Reset then single op: requester 2 sends a=0x40000000, b=0x40400000, c=0x3F800000 (2*3+1) -> req_ready=4'b0100 that cycle; 2 cycles later resp_valid=4'b0100, resp_id=2, resp_data=0x40E00000; in_flight goes 1,1,0.
- All four valid continuously from ptr=0 for 8 cycles -> grant order 0,1,2,3,0,1,2,3; responses appear in the same order lagging by 2 cycles; in_flight saturates at 2.
- Simultaneous request and response: a transfer in the same cycle as a response -> in_flight stays constant; no dropped or duplicated resp_valid.
- hold=1 with requesters 1 and 3 valid and 2 ops in flight -> req_ready=0; both in-flight responses still delivered; busy=0 afterwards. On hold=0, requester 3 is granted first if ptr=2.
- rst_n pulsed low mid-stream with 2 ops in flight -> all outputs 0 immediately (asynchronously); no response for the dropped ops after release; the first grant after release goes to the lowest valid index.
- FMA_LAT=3 build with a behavioural FMA model -> each response arrives exactly 4 cycles after its transfer with the correct id; in_flight peaks at 4.
